// File: rtl/alu_pkg.sv
// Shared constants and status struct for the ALU result selector.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  localparam int unsigned CH_CMP   = 0;
  localparam int unsigned CH_LOGIC = 1;
  localparam int unsigned CH_ARITH = 2;

  typedef struct packed {
    logic err;
    logic ovf;
    logic neg;
    logic zero;
  } alu_status_t;

  localparam int unsigned STATUS_W = $bits(alu_status_t);

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer; in_ready and out_valid come straight from flops.
module alu_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q, ready_q;
  logic             accept, xfer;

  assign accept = in_valid && ready_q;
  assign xfer   = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && !xfer) begin
          skid_d  = in_data;
          state_d = StTwo;
        end else if (accept && xfer) begin
          main_d = in_data;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (xfer) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != StEmpty);
      ready_q <= (state_d != StTwo);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/alu_result_sel.sv
// ALU output stage: channel select plus flag generation in front of a skid buffer.
// Optional sticky overflow status is built only when ALU_SEL_STICKY_EN is defined.
module alu_result_sel
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned NCH    = 3,
  parameter int unsigned OVF_CH = CH_ARITH,
  parameter int unsigned CW     = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CW-1:0]      ctrl,
  input  logic [NCH*WIDTH-1:0] ch_data,
  input  logic               ovf_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_ovf,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sticky_ovf,
  input  logic               clr_sticky
);

  logic [WIDTH-1:0] sel_data;
  logic             legal;
  alu_status_t      sel_status, out_status;
  logic [STATUS_W+WIDTH-1:0] buf_out;
  logic             accept;

  always_comb begin
    sel_data = '0;
    legal    = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ctrl == CW'(k)) begin
        sel_data = ch_data[k*WIDTH +: WIDTH];
        legal    = 1'b1;
      end
    end
    sel_status.err  = !legal;
    // An out-of-range OVF_CH must not alias onto a real channel after truncation.
    sel_status.ovf  = legal && (OVF_CH < NCH) && (ctrl == CW'(OVF_CH)) && ovf_in;
    sel_status.neg  = sel_data[WIDTH-1];
    sel_status.zero = (sel_data == '0);
  end

  alu_skid_buf #(
    .WIDTH(STATUS_W + WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({sel_status, sel_data}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (buf_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {out_status, out_data} = buf_out;
  assign out_ovf  = out_status.ovf;
  assign out_zero = out_status.zero;
  assign out_neg  = out_status.neg;
  assign out_err  = out_status.err;
  assign accept   = in_valid && in_ready;

`ifdef ALU_SEL_STICKY_EN
  logic sticky_q;

  // Set takes priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (accept && sel_status.ovf) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  logic unused_sticky_in;
  assign unused_sticky_in = clr_sticky ^ accept;
  assign sticky_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_sel.sv
// Bench for alu_result_sel: queue-based reference model plus directed literal checks.
module tb_alu_result_sel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ctrl = '0;
  logic [23:0] ch_data = '0;
  logic        ovf_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_ovf, out_zero, out_neg, out_err, out_valid;
  logic        out_ready = 1'b0;
  logic        sticky_ovf;
  logic        clr_sticky = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: entries held by the block, each {err, ovf, neg, zero, data}.
  logic [11:0] mq[$];
  logic [7:0]  seen[$];
  bit          sticky_m = 1'b0;
  int          xfer_cnt = 0;

  alu_result_sel dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl      (ctrl),
    .ch_data   (ch_data),
    .ovf_in    (ovf_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sticky_ovf(sticky_ovf),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] model_res(input logic [1:0] c, input logic [23:0] ch,
                                            input logic ov);
    logic [7:0] d;
    logic       e, o;
    if (int'(c) < 3) begin
      d = ch[int'(c)*8 +: 8];
      e = 1'b0;
      o = (c == 2'd2) && ov;
    end else begin
      d = 8'h00;
      e = 1'b1;
      o = 1'b0;
    end
    return {e, o, d[7], (d == 8'h00), d};
  endfunction

  always @(posedge clk) begin
    bit          acc, xf;
    logic [11:0] r;
    if (rst) begin
      mq.delete();
      sticky_m = 1'b0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      xf  = (mq.size() > 0) && out_ready;
      r   = model_res(ctrl, ch_data, ovf_in);
      if (xf) begin
        seen.push_back(mq[0][7:0]);
        xfer_cnt++;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(r);
`ifdef ALU_SEL_STICKY_EN
      if (acc && r[10]) sticky_m = 1'b1;
      else if (clr_sticky) sticky_m = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < 2});
      check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
      check("sticky_ovf", {31'b0, sticky_ovf}, {31'b0, sticky_m});
      if (mq.size() > 0)
        check("out_word", {20'b0, out_err, out_ovf, out_neg, out_zero, out_data},
              {20'b0, mq[0]});
    end
  end

  task automatic send(input logic [1:0] c, input logic [23:0] ch, input logic ov);
    int   cyc;
    logic rdy;
    cyc      = 0;
    ctrl     = c;
    ch_data  = ch;
    ovf_in   = ov;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!rdy && cyc < 50);
    if (!rdy) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'h00);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_flags", {28'b0, out_err, out_ovf, out_neg, out_zero}, 32'd0);
    check("rst_sticky", {31'b0, sticky_ovf}, 32'd0);

    // Basic select through the arithmetic channel, then the compare channel
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'd2, 24'h808080, 1'b1);
    @(negedge clk);
    check("sel2_data", {24'b0, out_data}, 32'h80);
    check("sel2_ovf", {31'b0, out_ovf}, 32'd1);
    check("sel2_neg", {31'b0, out_neg}, 32'd1);
    check("sel2_zero", {31'b0, out_zero}, 32'd0);
    send(2'd0, 24'h808080, 1'b1);
    @(negedge clk);
    check("sel0_data", {24'b0, out_data}, 32'h80);
    check("sel0_ovf", {31'b0, out_ovf}, 32'd0);

    // Illegal select
    send(2'd3, 24'h808080, 1'b1);
    @(negedge clk);
    check("ill_data", {24'b0, out_data}, 32'h00);
    check("ill_err", {31'b0, out_err}, 32'd1);
    check("ill_zero", {31'b0, out_zero}, 32'd1);
    check("ill_ovf", {31'b0, out_ovf}, 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: 4-cycle stall while streaming 0x01..0x05
    seen.delete();
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
      begin
        send(2'd1, 24'h000100, 1'b0);
        send(2'd1, 24'h000200, 1'b0);
        @(negedge clk);
        check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("bp_hold_data", {24'b0, out_data}, 32'h01);
        for (int v = 3; v <= 5; v++) send(2'd1, {8'h00, 8'(v), 8'h00}, 1'b0);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("bp_count", seen.size(), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      check("bp_order", {24'b0, seen[i]}, i + 1);

    // Full throughput
    xfer_cnt  = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ctrl      = 2'd0;
    for (int i = 0; i < 16; i++) begin
      ch_data = {16'h0000, 8'(i) + 8'h10};
      @(negedge clk);
      check("thru_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("thru_xfers", xfer_cnt, 32'd16);

    // Reset while two entries are held
    out_ready = 1'b0;
    send(2'd1, 24'h00AA00, 1'b0);
    send(2'd1, 24'h00BB00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_data", {24'b0, out_data}, 32'h00);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Sticky overflow
    send(2'd2, 24'h7F0000, 1'b1);
`ifdef ALU_SEL_STICKY_EN
    for (int i = 0; i < 5; i++) send(2'd1, {8'h00, 8'(i + 1), 8'h00}, 1'b1);
    @(negedge clk);
    check("sticky_held", {31'b0, sticky_ovf}, 32'd1);
    @(posedge clk);
    #1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky_clr", {31'b0, sticky_ovf}, 32'd0);
    @(posedge clk);
    #1;
    clr_sticky = 1'b1;
    send(2'd2, 24'h7F0000, 1'b1);
    clr_sticky = 1'b0;
    @(negedge clk);
    check("sticky_set_wins", {31'b0, sticky_ovf}, 32'd1);
`else
    @(negedge clk);
    check("sticky_tied_low", {31'b0, sticky_ovf}, 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
